mult_div_unit: RTL

Iterative 32-bit multiply/divide unit, directly downstream of the register file. It consumes the two register read values (Read_Data1/Read_Data2) as operands and computes MULT/MULTU/DIV/DIVU over several cycles, holding the result in internal HI/LO registers. The control unit observes Busy/Done to stall the pipeline and later reads Hi/Lo (MFHI/MFLO) back towards the register file write port.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mdu_step.sv | 37 +++
 rtl/mult_div_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mdu_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the register file, control unit and the MDU.
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] Operand_A;
  logic [DATA_WIDTH-1:0] Operand_B;
  logic                  Hi_Write;
  logic                  Lo_Write;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic                  Busy;
  logic                  Done;
  logic                  Div_By_Zero;
  logic [DATA_WIDTH-1:0] Hi;
  logic [DATA_WIDTH-1:0] Lo;

  modport master (
    output Start, Op, Operand_A, Operand_B, Hi_Write, Lo_Write, Write_Data,
    input  Busy, Done, Div_By_Zero, Hi, Lo
  );

  modport slave (
    input  Start, Op, Operand_A, Operand_B, Hi_Write, Lo_Write, Write_Data,
    output Busy, Done, Div_By_Zero, Hi, Lo
  );
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
module mdu_step
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic                    in_bit,
  input  op_e                     op,
  output logic [2*DATA_WIDTH-1:0] acc_next,
  output logic                    q_bit
);
  localparam int W = DATA_WIDTH;

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] trial;
  logic       borrow;

  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + (in_bit ? {1'b0, operand} : '0);
    shifted  = {acc[2*W-1:W], in_bit};
    borrow   = shifted < {1'b0, operand};
    trial    = shifted - {1'b0, operand};
    acc_next = '0;
    q_bit    = 1'b0;
    unique case (op)
      OP_MULT, OP_MULTU: acc_next = {sum, acc[W-1:1]};
      default: begin
        // Quotient LSB is left clear here; the owner merges q_bit in.
        q_bit    = ~borrow;
        acc_next = {(borrow ? shifted[W-1:0] : trial[W-1:0]), acc[W-2:0], 1'b0};
      end
    endcase
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; fixed DATA_WIDTH+1 cycle latency.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset_n,
  mult_div_unit_if.slave   bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  state_e               state;
  op_e                  op_q;
  logic [W-1:0]         a_q, b_q;
  logic                 sign_a, sign_b;
  logic [2*W-1:0]       acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         hi_q, lo_q;
  logic                 busy_q, done_q, dbz_q;

  // Operand capture: magnitudes for signed ops, raw values otherwise.
  logic   in_signed, in_sa, in_sb;
  assign in_signed = ~bus.Op[0];
  assign in_sa     = in_signed & bus.Operand_A[W-1];
  assign in_sb     = in_signed & bus.Operand_B[W-1];

  logic           is_div, step_bit, q_bit;
  logic [W-1:0]   step_operand;
  logic [2*W-1:0] acc_next;
  assign is_div       = op_q[1];
  assign step_bit     = is_div ? a_q[LAST - cnt] : b_q[cnt];
  assign step_operand = is_div ? b_q : a_q;

  mdu_step #(.DATA_WIDTH(W)) u_step (
    .acc      (acc),
    .operand  (step_operand),
    .in_bit   (step_bit),
    .op       (op_q),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  // Sign correction applied in FIX.
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot, rem, a_raw;
  logic           b_zero;
  assign prod   = (op_q == OP_MULT && (sign_a ^ sign_b)) ? -acc : acc;
  assign quot   = (op_q == OP_DIV && (sign_a ^ sign_b)) ? -acc[W-1:0] : acc[W-1:0];
  assign rem    = (op_q == OP_DIV && sign_a) ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign a_raw  = sign_a ? -a_q : a_q;
  assign b_zero = (b_q == '0);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            op_q   <= op_e'(bus.Op);
            a_q    <= in_sa ? -bus.Operand_A : bus.Operand_A;
            b_q    <= in_sb ? -bus.Operand_B : bus.Operand_B;
            sign_a <= in_sa;
            sign_b <= in_sb;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end else begin
            if (bus.Hi_Write) hi_q <= bus.Write_Data;
            if (bus.Lo_Write) lo_q <= bus.Write_Data;
          end
        end
        ST_RUN: begin
          acc <= acc_next | {{(2*W-1){1'b0}}, q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div && b_zero) begin
            lo_q <= '1;
            hi_q <= a_raw;
          end else if (is_div) begin
            lo_q <= quot;
            hi_q <= rem;
          end else begin
            hi_q <= prod[2*W-1:W];
            lo_q <= prod[W-1:0];
          end
          done_q <= 1'b1;
          dbz_q  <= is_div & b_zero;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Div_By_Zero = dbz_q;
  assign bus.Hi          = hi_q;
  assign bus.Lo          = lo_q;
endmodule
